// File: rtl/ws2811_frame_ctrl.sv
// ---------------------------------------------------------------------------
// ws2811_frame_ctrl
//
// Pixel frame buffer between a host and a WS2811 bit-serial driver. The host
// writes 24-bit colours by pixel index. The driver pulls one colour per
// drv_data_request, and the colour is presented one cycle after the request.
//
// Build option (macro WS2811_FRAME_CTRL_DBUF_EN):
//   defined   : two banks. The host writes the back bank. A commit pulse
//               requests a front/back swap, and the swap happens at the next
//               frame start (a request with rd_ptr == 0).
//   undefined : one bank serves as both front and back, so writes are
//               visible immediately. commit is ignored, commit_pending stays
//               0 and wr_ready stays 1.
//
// Ports:
//   clk               clock, rising edge
//   rst               asynchronous active-high reset
//   wr_valid/wr_ready host write handshake
//   wr_addr, wr_rgb   pixel index and colour {R,G,B}; out-of-range indices
//                     are accepted and dropped
//   commit            one-cycle pulse requesting a bank swap
//   commit_pending    commit accepted, swap not yet done
//   blank             forces zero colour onto the outputs
//   drv_data_request  driver pulls the next pixel
//   red/green/blue_out colour for the driver, held between requests
//   frame_done        one-cycle pulse after the last pixel of a frame
//   frame_count       completed frames, wraps at 16 bits
// ---------------------------------------------------------------------------
module ws2811_frame_ctrl #(
   parameter int NUM_LEDS = 4,
   parameter int ADDR_W   = (NUM_LEDS > 2) ? $clog2(NUM_LEDS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [23:0]       wr_rgb,
   input  logic              commit,
   output logic              commit_pending,
   input  logic              blank,
   input  logic              drv_data_request,
   output logic [7:0]        red_out,
   output logic [7:0]        green_out,
   output logic [7:0]        blue_out,
   output logic              frame_done,
   output logic [15:0]       frame_count
);

`ifdef WS2811_FRAME_CTRL_DBUF_EN
   localparam int NUM_BANKS = 2;
`else
   localparam int NUM_BANKS = 1;
`endif

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } swap_state_t;

   swap_state_t       state_reg, state_next;
   logic              swap_now;
   logic              bank_sel_reg;
   logic              front_sel;
   logic              back_sel;
   logic [ADDR_W-1:0] rd_ptr_reg;
   logic [23:0]       colour_reg;
   logic              frame_done_reg;
   logic [15:0]       frame_count_reg;
   logic              frame_start;
   logic              last_pixel;
   logic              wr_fire;
   logic [23:0]       bank_rd [NUM_BANKS];
   logic [23:0]       rd_rgb;

   assign frame_start    = drv_data_request && (rd_ptr_reg == '0);
   assign last_pixel     = (rd_ptr_reg == ADDR_W'(NUM_LEDS - 1));
   assign commit_pending = (state_reg == PENDING);
   assign wr_ready       = !commit_pending;
   assign wr_fire        = wr_valid && wr_ready && (int'(wr_addr) < NUM_LEDS);

`ifdef WS2811_FRAME_CTRL_DBUF_EN
   // At a swapping frame start the read already targets the new front bank.
   assign front_sel = swap_now ? ~bank_sel_reg : bank_sel_reg;
   assign back_sel  = ~bank_sel_reg;
`else
   // With a single bank, front and back are the same bank. bank_sel_reg
   // never toggles because swap_now is never raised.
   logic unused_commit;
   assign unused_commit = commit;
   assign front_sel     = bank_sel_reg;
   assign back_sel      = bank_sel_reg;
`endif

   // ---------------- swap control FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      swap_now   = 1'b0;
      case (state_reg)
         IDLE: begin
`ifdef WS2811_FRAME_CTRL_DBUF_EN
            // A commit that coincides with a frame start only arms the swap.
            // The swap waits for the following frame start.
            if (commit) state_next = PENDING;
`endif
         end
         PENDING: begin
            if (frame_start) begin
               state_next = IDLE;
               swap_now   = 1'b1;
            end
         end
      endcase
   end

   // ---------------- pixel banks ----------------
   // Contents are not reset. A write can only reach the back bank, and
   // writes are blocked while a swap is pending, so no write collides with
   // the swap.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
         logic [23:0] mem [NUM_LEDS];

         always_ff @(posedge clk) begin
            if (wr_fire && (back_sel == 1'(gi))) begin
               mem[wr_addr] <= wr_rgb;
            end
         end

         assign bank_rd[gi] = (front_sel == 1'(gi)) ? mem[rd_ptr_reg] : 24'h0;
      end
   endgenerate

   always_comb begin
      rd_rgb = 24'h0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         rd_rgb = rd_rgb | bank_rd[i];
      end
   end

   // ---------------- read side / frame bookkeeping ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_reg      <= '0;
         bank_sel_reg    <= 1'b0;
         colour_reg      <= 24'h0;
         frame_done_reg  <= 1'b0;
         frame_count_reg <= 16'h0;
      end else begin
         frame_done_reg <= drv_data_request && last_pixel;
         if (swap_now) begin
            bank_sel_reg <= ~bank_sel_reg;
         end
         if (drv_data_request) begin
            colour_reg <= blank ? 24'h0 : rd_rgb;
            rd_ptr_reg <= last_pixel ? '0 : rd_ptr_reg + 1'b1;
            if (last_pixel) begin
               frame_count_reg <= frame_count_reg + 16'd1;
            end
         end
      end
   end

   assign red_out     = colour_reg[23:16];
   assign green_out   = colour_reg[15:8];
   assign blue_out    = colour_reg[7:0];
   assign frame_done  = frame_done_reg;
   assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_ws2811_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ws2811_frame_ctrl
//
// Directed bench for ws2811_frame_ctrl with NUM_LEDS = 4. The stimulus
// process pushes the hand-computed colour and frame_done value for each
// driver request into a queue. A separate monitor pops one entry when a
// request was sampled on the previous edge and compares it with the
// outputs. On idle cycles the monitor checks that the colour is held and
// that frame_done stays low. The sequence follows the build option
// (WS2811_FRAME_CTRL_DBUF_EN).
// ---------------------------------------------------------------------------
module tb_ws2811_frame_ctrl;

   logic        clk;
   logic        rst;
   logic        wr_valid;
   logic        wr_ready;
   logic [1:0]  wr_addr;
   logic [23:0] wr_rgb;
   logic        commit;
   logic        commit_pending;
   logic        blank;
   logic        drv_data_request;
   logic [7:0]  red_out, green_out, blue_out;
   logic        frame_done;
   logic [15:0] frame_count;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic        done;
      logic [23:0] rgb;
   } exp_t;
   exp_t exp_q[$];

   ws2811_frame_ctrl #(.NUM_LEDS(4)) dut (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_rgb(wr_rgb),
      .commit(commit), .commit_pending(commit_pending),
      .blank(blank), .drv_data_request(drv_data_request),
      .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
      .frame_done(frame_done), .frame_count(frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, checks=%0d", n_checks);
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   // Advance one cycle and drop all one-cycle pulses.
   task automatic cyc();
      @(posedge clk);
      #1;
      wr_valid         = 1'b0;
      commit           = 1'b0;
      drv_data_request = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [23:0] c);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_rgb   = c;
      cyc();
   endtask

   // A request followed by one idle cycle, so the hold check runs.
   task automatic rq(input logic [23:0] c, input logic done);
      drv_data_request = 1'b1;
      exp_q.push_back({done, c});
      cyc();
      cyc();
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin : monitor
      logic        f;
      logic [23:0] last;
      exp_t        e;
      last = 24'h0;
      forever begin
         @(posedge clk);
         f = drv_data_request && !rst;
         @(negedge clk);
         if (rst) begin
            last = 24'h0;
         end else if (f) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_output: got rgb 0x%06h with no expected entry",
                        {red_out, green_out, blue_out});
            end else begin
               n_checks--;
               e = exp_q.pop_front();
               chk("pixel_rgb", {8'h0, red_out, green_out, blue_out}, {8'h0, e.rgb});
               chk("pixel_done", {31'h0, frame_done}, {31'h0, e.done});
               last = e.rgb;
            end
         end else begin
            n_checks++;
            if ({red_out, green_out, blue_out} !== last || frame_done !== 1'b0) begin
               n_fail++;
               $display("FAIL idle_hold: got rgb 0x%06h done %0b expected rgb 0x%06h done 0",
                        {red_out, green_out, blue_out}, frame_done, last);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; wr_valid = 1'b0; wr_addr = 2'd0; wr_rgb = 24'h0;
      commit = 1'b0; blank = 1'b0; drv_data_request = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      cyc();
      chk("reset_rgb", {8'h0, red_out, green_out, blue_out}, 32'h0);
      chk("reset_frame_count", {16'h0, frame_count}, 32'h0);
      chk("reset_pending", {31'h0, commit_pending}, 32'h0);
      chk("reset_wr_ready", {31'h0, wr_ready}, 32'h1);
      chk("reset_frame_done", {31'h0, frame_done}, 32'h0);

`ifdef WS2811_FRAME_CTRL_DBUF_EN
      // First commit: fill back bank 1, swap at the first frame start.
      wr(2'd0, 24'h112233); wr(2'd1, 24'h112233);
      wr(2'd2, 24'h112233); wr(2'd3, 24'h112233);
      commit = 1'b1; cyc();
      chk("commit_pending_set", {31'h0, commit_pending}, 32'h1);
      chk("wr_ready_low_pending", {31'h0, wr_ready}, 32'h0);
      wr(2'd0, 24'hDEADBE);                      // refused, wr_ready is low
      chk("still_pending_before_frame", {31'h0, commit_pending}, 32'h1);
      rq(24'h112233, 1'b0);
      chk("pending_cleared_by_frame_start", {31'h0, commit_pending}, 32'h0);
      rq(24'h112233, 1'b0); rq(24'h112233, 1'b0); rq(24'h112233, 1'b1);
      chk("frame_count_1", {16'h0, frame_count}, 32'd1);

      // Uncommitted writes to back bank 0 stay invisible.
      wr(2'd0, 24'hA1A1A1); wr(2'd1, 24'hB2B2B2);
      wr(2'd2, 24'hFF0000); wr(2'd3, 24'hC3C3C3);
      rq(24'h112233, 1'b0); rq(24'h112233, 1'b0);
      rq(24'h112233, 1'b0); rq(24'h112233, 1'b1);
      commit = 1'b1; cyc();
      rq(24'hA1A1A1, 1'b0); rq(24'hB2B2B2, 1'b0);
      rq(24'hFF0000, 1'b0); rq(24'hC3C3C3, 1'b1);
      chk("frame_count_3", {16'h0, frame_count}, 32'd3);

      // Blanked frame still counts.
      blank = 1'b1;
      rq(24'h0, 1'b0); rq(24'h0, 1'b0); rq(24'h0, 1'b0); rq(24'h0, 1'b1);
      blank = 1'b0;
      chk("frame_count_blank", {16'h0, frame_count}, 32'd4);

      // Reset mid-frame with a commit pending: commit is discarded.
      rq(24'hA1A1A1, 1'b0); rq(24'hB2B2B2, 1'b0);
      commit = 1'b1; cyc();
      chk("pending_before_rst", {31'h0, commit_pending}, 32'h1);
      rst = 1'b1; cyc();
      chk("rst_pending", {31'h0, commit_pending}, 32'h0);
      chk("rst_rgb", {8'h0, red_out, green_out, blue_out}, 32'h0);
      chk("rst_frame_count", {16'h0, frame_count}, 32'h0);
      rst = 1'b0; cyc();
      rq(24'hA1A1A1, 1'b0); rq(24'hB2B2B2, 1'b0);
      rq(24'hFF0000, 1'b0); rq(24'hC3C3C3, 1'b1);
      chk("frame_count_after_rst", {16'h0, frame_count}, 32'd1);

      // Commit plus write plus frame-start request in one cycle: no swap yet.
      wr_valid = 1'b1; wr_addr = 2'd0; wr_rgb = 24'h0A0B0C;
      commit = 1'b1; drv_data_request = 1'b1;
      exp_q.push_back({1'b0, 24'hA1A1A1});
      cyc(); cyc();
      chk("pending_after_coincident_commit", {31'h0, commit_pending}, 32'h1);
      rq(24'hB2B2B2, 1'b0); rq(24'hFF0000, 1'b0);
      chk("wr_ready_low_mid_frame", {31'h0, wr_ready}, 32'h0);
      rq(24'hC3C3C3, 1'b1);
      rq(24'h0A0B0C, 1'b0);
      chk("pending_cleared_second_frame", {31'h0, commit_pending}, 32'h0);
      rq(24'h112233, 1'b0); rq(24'h112233, 1'b0); rq(24'h112233, 1'b1);
      chk("frame_count_final", {16'h0, frame_count}, 32'd3);
`else
      // Single bank: writes are visible at once, commit has no effect.
      wr(2'd0, 24'h112233); wr(2'd1, 24'h0000AA);
      wr(2'd2, 24'h445566); wr(2'd3, 24'h778899);
      commit = 1'b1; cyc();
      chk("commit_ignored_pending", {31'h0, commit_pending}, 32'h0);
      chk("commit_ignored_wr_ready", {31'h0, wr_ready}, 32'h1);
      rq(24'h112233, 1'b0); rq(24'h0000AA, 1'b0);
      rq(24'h445566, 1'b0); rq(24'h778899, 1'b1);
      chk("frame_count_1", {16'h0, frame_count}, 32'd1);

      wr(2'd2, 24'hFF0000);
      rq(24'h112233, 1'b0); rq(24'h0000AA, 1'b0);
      rq(24'hFF0000, 1'b0); rq(24'h778899, 1'b1);
      chk("frame_count_2", {16'h0, frame_count}, 32'd2);

      blank = 1'b1;
      rq(24'h0, 1'b0); rq(24'h0, 1'b0); rq(24'h0, 1'b0); rq(24'h0, 1'b1);
      blank = 1'b0;
      chk("frame_count_blank", {16'h0, frame_count}, 32'd3);

      rq(24'h112233, 1'b0); rq(24'h0000AA, 1'b0);
      commit = 1'b1; cyc();
      rst = 1'b1; cyc();
      chk("rst_pending", {31'h0, commit_pending}, 32'h0);
      chk("rst_rgb", {8'h0, red_out, green_out, blue_out}, 32'h0);
      chk("rst_frame_count", {16'h0, frame_count}, 32'h0);
      rst = 1'b0; cyc();
      rq(24'h112233, 1'b0); rq(24'h0000AA, 1'b0);
      rq(24'hFF0000, 1'b0); rq(24'h778899, 1'b1);
      chk("frame_count_after_rst", {16'h0, frame_count}, 32'd1);
      chk("wr_ready_constant", {31'h0, wr_ready}, 32'h1);
`endif

      repeat (3) cyc();
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
